// File: rtl/ysyx_24070017_ifu.sv
// Instruction fetch unit: REQ -> WAIT -> HOLD with one outstanding read; IFU_TIMEOUT_EN adds a response timeout plus a DROP state.
// Latency >= 3 cycles from request to inst_valid; req_addr holds until req_ready, inst/pc/fault hold until inst_ready.
module ysyx_24070017_ifu #(
  parameter int                     WORD_LENGTH = 32,
  parameter logic [WORD_LENGTH-1:0] RESET_PC    = 32'h80000000,
  parameter int                     TIMEOUT     = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   req_valid,
  input  logic                   req_ready,
  output logic [WORD_LENGTH-1:0] req_addr,
  input  logic                   rsp_valid,
  output logic                   rsp_ready,
  input  logic [31:0]            rsp_data,
  input  logic                   rsp_err,
  output logic                   inst_valid,
  input  logic                   inst_ready,
  output logic [31:0]            inst,
  output logic [WORD_LENGTH-1:0] pc,
  output logic                   fault,
  input  logic [WORD_LENGTH-1:0] next_pc
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_DROP = 2'd3
  } state_t;

  state_t state, state_nxt;
  logic   next_misal;
  logic   tmo_hit;
  logic   drop_pend;

  assign next_misal = |next_pc[1:0];
  assign req_addr   = pc;

`ifdef IFU_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] wait_cnt;
  logic             pc_misal;

  assign pc_misal = |pc[1:0];
  // The response wins if it lands in the expiry cycle, so no DROP is needed then.
  assign tmo_hit  = (state == S_WAIT) && !rsp_valid && (wait_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt  <= '0;
      drop_pend <= 1'b0;
    end else begin
      if (state == S_REQ)
        wait_cnt <= '0;
      else if (state == S_WAIT)
        wait_cnt <= wait_cnt + CNT_W'(1);
      if (tmo_hit)
        drop_pend <= 1'b1;
      else if (state == S_HOLD && inst_ready)
        drop_pend <= 1'b0;
    end
  end
`else
  localparam int unused_timeout = TIMEOUT;

  assign tmo_hit   = 1'b0;
  assign drop_pend = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst)
      state <= S_REQ;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_REQ:  if (req_ready) state_nxt = S_WAIT;
      S_WAIT: if (rsp_valid || tmo_hit) state_nxt = S_HOLD;
      // A misaligned target never reaches the bus: it re-enters HOLD as a fault.
      S_HOLD: if (inst_ready) state_nxt = drop_pend ? S_DROP : (next_misal ? S_HOLD : S_REQ);
`ifdef IFU_TIMEOUT_EN
      S_DROP: if (rsp_valid) state_nxt = pc_misal ? S_HOLD : S_REQ;
`endif
      default: state_nxt = S_REQ;
    endcase
  end

  always_comb begin
    req_valid  = !rst && (state == S_REQ);
    rsp_ready  = !rst && ((state == S_WAIT) || (state == S_DROP));
    inst_valid = !rst && (state == S_HOLD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc    <= RESET_PC;
      inst  <= 32'h0;
      fault <= 1'b0;
    end else begin
      case (state)
        S_WAIT: begin
          if (rsp_valid) begin
            inst  <= rsp_err ? 32'h0 : rsp_data;
            fault <= rsp_err;
          end else if (tmo_hit) begin
            inst  <= 32'h0;
            fault <= 1'b1;
          end
        end
        S_HOLD: begin
          if (inst_ready) begin
            pc <= next_pc;
            if (next_misal) begin
              inst  <= 32'h0;
              fault <= 1'b1;
            end
          end
        end
`ifdef IFU_TIMEOUT_EN
        S_DROP: begin
          if (rsp_valid && pc_misal) begin
            inst  <= 32'h0;
            fault <= 1'b1;
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: doc/ysyx_24070017_ifu.md
Name: ysyx_24070017_ifu

Overview:
- Instruction fetch unit directly upstream of the single-cycle core; produces the `inst` word and the PC the core executes.
- Owns the fetch PC, issues one-outstanding-request reads to instruction memory over a valid/ready bus, and holds the fetched word until the core accepts it.
- Receives the core's dynamic next PC at the accept handshake.

Parameters:
- WORD_LENGTH, 32, width of PC, address and instruction.
- RESET_PC, 32'h80000000, first fetch address after reset.
- TIMEOUT, 255, cycles to wait for a response; used only with IFU_TIMEOUT_EN.

Ports:
- clk  in  1  clock; single clock domain.
- rst  in  1  synchronous active-high reset.
- req_valid  out  1  fetch request valid.
- req_ready  in  1  memory accepts request.
- req_addr  out  WORD_LENGTH  fetch address, word aligned.
- rsp_valid  in  1  response valid.
- rsp_ready  out  1  IFU accepts response.
- rsp_data  in  32  instruction word.
- rsp_err  in  1  bus error on this response.
- inst_valid  out  1  inst/pc/fault valid to core.
- inst_ready  in  1  core consumes instruction this cycle.
- inst  out  32  fetched instruction.
- pc  out  WORD_LENGTH  address of inst.
- fault  out  1  instruction access fault; inst is 32'h0 when set.
- next_pc  in  WORD_LENGTH  core's dnpc, sampled on inst handshake.

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values: state=REQ, fetch PC=RESET_PC, req_valid=0 in the reset cycle, rsp_ready=0, inst_valid=0, inst=0, fault=0, pc=RESET_PC.
- The memory side is reset by the same `rst`; any response in flight at reset is discarded.
- State REQ:
  - req_valid=1, req_addr=fetch PC.
  - On req_valid&req_ready, go to WAIT.
  - req_addr is stable while req_valid=1 and not accepted.
- State WAIT:
  - rsp_ready=1.
  - On rsp_valid, latch inst=rsp_data (32'h0 if rsp_err), fault=rsp_err, then go to HOLD.
- State HOLD:
  - inst_valid=1; inst, pc and fault are stable until the handshake.
  - On inst_valid&inst_ready: fetch PC <= next_pc, inst_valid <= 0, go to REQ.
- Latency: minimum 3 cycles from request issue to inst_valid (REQ→WAIT, response, HOLD). Back-to-back throughput is one instruction per 3 cycles when memory is zero-wait.
- Misaligned next_pc (bits[1:0]≠0):
  - No bus request is issued; go directly to HOLD with fault=1, inst=0, pc=next_pc.
  - The fault is reported one cycle after the handshake.
- Only one request is outstanding at a time.
- rsp_valid outside WAIT (or DROP) is ignored; rsp_ready=0 in those states.
- inst_ready while inst_valid=0 has no effect.
- Decode of 32'h00100073 (ebreak) is not done here; the word is passed through unchanged.
- Reset asserted in any state: next cycle is as after reset; latched inst is cleared.

Optional Feature:
- Macro IFU_TIMEOUT_EN.
- Defined:
  - An 8-bit (clog2(TIMEOUT+1)) counter runs in WAIT and clears on entry.
  - When the count reaches TIMEOUT with no rsp_valid, go to HOLD with fault=1, inst=0.
  - After that handshake, go to DROP instead of REQ. DROP keeps rsp_ready=1, discards exactly one late response, then enters REQ with the new PC.
  - A redundant DROP is avoided if the response arrives in the expiry cycle; the response wins.
- Undefined: no counter and no DROP state; WAIT waits indefinitely.

Test Plan:
- Reset, zero-wait memory returning 32'h00000013 at 0x80000000: req_addr=0x80000000; inst_valid rises 3 cycles after reset release with pc=0x80000000, fault=0.
- Handshake with next_pc=0x80000004, then next_pc=0x80000010 (branch): following req_addr=0x80000004, then 0x80000010; pc outputs match.
- req_ready low for 5 cycles, then rsp_valid delayed 4 cycles: req_addr held constant, single request, inst latched only on rsp_valid, inst_ready held 0 for 3 cycles keeps inst/pc stable.
- rsp_err=1 with rsp_data=0xDEADBEEF: inst=0, fault=1; next_pc=0x80000002 at handshake: no req_valid, fault=1, pc=0x80000002.
- Reset asserted during WAIT and during HOLD: next cycle state REQ, req_addr=RESET_PC, inst_valid=0, stale response ignored.
- IFU_TIMEOUT_EN with TIMEOUT=8 and no response: fault at cycle 8 of WAIT; a late response after handshake is dropped; next req_addr=next_pc.
